uart_stim_tx: RTL and testbench

Synthesizable 8-bit UART transmitter with a small input FIFO, driving the `uart_rx` pin of `top` from bench- or FPGA-side logic. It is the upstream counterpart of the UART receive monitor on the `uart_tx` line. A byte-stream producer pushes bytes with a valid/ready handshake. The block serialises them as 8N1 frames (or 8E1 with parity) at a fixed baud rate, with no gap between frames while data is queued.

---
 rtl/uart_stim_tx.sv | 179 +++++++++++++++++
 tb/tb_uart_stim_tx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stim_tx.sv
// 8-bit UART transmitter (8N1, or 8E1 with PARITY_EN) fed by a small circular FIFO.
// The line output is registered from the FSM state, so tx_o lags the state register by one clock.
module uart_stim_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 3_125_000,
    parameter int PARITY_EN  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        done_o
);

    localparam int DIV   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   baud_cnt_reg, baud_cnt_next;
    logic [2:0]         bit_idx_reg, bit_idx_next;
    logic [7:0]         byte_reg;
    logic               tx_reg, tx_next;
    logic               done_reg;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               baud_last;
    logic               stop_end;

    // ready depends only on the registered level, never on a same-cycle pop
    assign ready_o    = (level_reg != LEVEL_FULL);
    assign push       = valid_i && ready_o;
    assign fifo_empty = (level_reg == '0);
    assign baud_last  = (baud_cnt_reg == BAUD_LAST);

    assign tx_o    = tx_reg;
    assign busy_o  = (state_reg != ST_IDLE);
    assign level_o = level_reg;
    assign done_o  = done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !push) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

    // Storage and head read kept reset-free so the array maps onto RAM
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= data_i;
        end
        if (pop) begin
            byte_reg <= fifo_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            tx_reg       <= tx_next;
            done_reg     <= stop_end;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg + 1'b1;
        bit_idx_next  = bit_idx_reg;
        pop           = 1'b0;
        stop_end      = 1'b0;
        tx_next       = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                baud_cnt_next = '0;
                bit_idx_next  = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                tx_next = 1'b0;
                if (baud_last) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = ST_DATA;
                end
            end

            ST_DATA: begin
                tx_next = byte_reg[bit_idx_reg];
                if (baud_last) begin
                    baud_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end

            ST_PARITY: begin
                tx_next = ^byte_reg;
                if (baud_last) begin
                    baud_cnt_next = '0;
                    state_next    = ST_STOP;
                end
            end

            ST_STOP: begin
                tx_next = 1'b1;
                if (baud_last) begin
                    baud_cnt_next = '0;
                    stop_end      = 1'b1;
                    // chain straight into the next start bit when data is waiting
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                baud_cnt_next = '0;
                state_next    = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Bench for uart_stim_tx: an 8N1 instance and an 8E1 instance, a bit-level receive monitor
// per line checking against a byte scoreboard, a vector table, and timing corner sequences.
module tb_uart_stim_tx;

    localparam int DIV = 16;

    typedef logic [159:0] val_t;

    typedef struct packed {
        logic [7:0] b;
        logic       par;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       acc;
        logic       tx;
        logic       ready;
        logic       busy;
        logic [2:0] level;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a, valid_a, ready_a, tx_a, busy_a, done_a;
    logic [7:0] data_a;
    logic [2:0] level_a;
    logic       rst_b, valid_b, ready_b, tx_b, busy_b, done_b;
    logic [7:0] data_b;
    logic [2:0] level_b;

    uart_stim_tx #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (3_125_000),
        .PARITY_EN (0),
        .FIFO_DEPTH(4)
    ) dut_a (
        .clk    (clk),
        .rst    (rst_a),
        .data_i (data_a),
        .valid_i(valid_a),
        .ready_o(ready_a),
        .tx_o   (tx_a),
        .busy_o (busy_a),
        .level_o(level_a),
        .done_o (done_a)
    );

    uart_stim_tx #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (3_125_000),
        .PARITY_EN (1),
        .FIFO_DEPTH(4)
    ) dut_b (
        .clk    (clk),
        .rst    (rst_b),
        .data_i (data_b),
        .valid_i(valid_b),
        .ready_o(ready_b),
        .tx_o   (tx_b),
        .busy_o (busy_b),
        .level_o(level_b),
        .done_o (done_b)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input val_t act, input val_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   fall0[$];
    int   fall1[$];
    int   rx_cnt[2];
    int   done_cnt[2];
    bit   act[2];
    int   cnt[2];
    logic [7:0] sh[2];
    logic par[2];
    int   last_fall[2];
    logic prev_done[2];

    // One negedge step of the receive monitor for line m (0: 8N1, 1: 8E1)
    task automatic mon_step(input int m, input logic tx, input logic rs, input logic dn);
        int   nb;
        int   j;
        int   qsz;
        exp_t e;
        nb = (m == 0) ? 10 : 11;
        if (dn === 1'b1) begin
            done_cnt[m]++;
            check($sformatf("done_pos%0d", m), val_t'(cyc - last_fall[m]), val_t'(nb * DIV - 1));
            check($sformatf("done_gap%0d", m), val_t'(prev_done[m]), val_t'(0));
        end
        prev_done[m] = dn;
        if (rs === 1'b1) begin
            act[m] = 1'b0;
        end else if (!act[m]) begin
            if (tx === 1'b0) begin
                act[m]       = 1'b1;
                cnt[m]       = 0;
                last_fall[m] = cyc;
                if (m == 0) fall0.push_back(cyc);
                else        fall1.push_back(cyc);
            end
        end else begin
            cnt[m]++;
            if (cnt[m] % DIV == DIV / 2) begin
                j = cnt[m] / DIV;
                if (j == 0) begin
                    check($sformatf("start_bit%0d", m), val_t'(tx), val_t'(0));
                end else if (j <= 8) begin
                    sh[m][j-1] = tx;
                end else if (j < nb - 1) begin
                    par[m] = tx;
                end else begin
                    check($sformatf("stop_bit%0d", m), val_t'(tx), val_t'(1));
                    rx_cnt[m]++;
                    act[m] = 1'b0;
                    qsz = (m == 0) ? exp_q0.size() : exp_q1.size();
                    check($sformatf("rx_queued%0d", m), val_t'(qsz != 0), val_t'(1));
                    if (qsz != 0) begin
                        e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("rx_byte%0d", m), val_t'(sh[m]), val_t'(e.b));
                        if (m == 1) check("rx_parity", val_t'(par[m]), val_t'(e.par));
                    end
                end
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0; cnt[m] = 0; rx_cnt[m] = 0; done_cnt[m] = 0;
            last_fall[m] = 0; prev_done[m] = 1'b0; sh[m] = 8'h00; par[m] = 1'b0;
        end
        forever begin
            @(negedge clk);
            mon_step(0, tx_a, rst_a, done_a);
            mon_step(1, tx_b, rst_b, done_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int m, input int n, input int budget);
        int k;
        k = 0;
        while (rx_cnt[m] < n && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("wait_rx%0d", m), val_t'(rx_cnt[m] >= n), val_t'(1));
    endtask

    vec_t vecs[11];
    int   c, f, c_a, f0, d0, r0;
    logic [159:0] wave, exp_wave;
    logic [9:0]   fb;

    initial begin
        rst_a = 1'b1; valid_a = 1'b0; data_a = 8'h00;
        rst_b = 1'b1; valid_b = 1'b0; data_b = 8'h00;
        c_a = 0;

        //            rst valid data  acc  tx rdy busy lvl done
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0};

        // Reset, then a 5-byte burst into a 4-deep FIFO (sixth byte offered while full)
        for (int i = 0; i < 11; i++) begin
            if (i == 4) c_a = cyc;
            rst_a   = vecs[i].rst;
            rst_b   = vecs[i].rst;
            valid_a = vecs[i].valid;
            data_a  = vecs[i].data;
            tick();
            if (vecs[i].acc) exp_q0.push_back('{vecs[i].data, 1'b0});
            check($sformatf("v%0d_tx", i),    val_t'(tx_a),    val_t'(vecs[i].tx));
            check($sformatf("v%0d_ready", i), val_t'(ready_a), val_t'(vecs[i].ready));
            check($sformatf("v%0d_busy", i),  val_t'(busy_a),  val_t'(vecs[i].busy));
            check($sformatf("v%0d_level", i), val_t'(level_a), val_t'(vecs[i].level));
            check($sformatf("v%0d_done", i),  val_t'(done_a),  val_t'(vecs[i].done));
        end
        valid_a = 1'b0;

        wait_rx(0, 5, 1000);
        check("burst_frames", val_t'(fall0.size()), val_t'(5));
        if (fall0.size() == 5) begin
            check("burst_first_fall", val_t'(fall0[0]), val_t'(c_a + 3));
            for (int i = 1; i < 5; i++)
                check($sformatf("burst_gap%0d", i), val_t'(fall0[i] - fall0[i-1]), val_t'(10 * DIV));
        end
        repeat (20) tick();
        check("burst_busy_end", val_t'(busy_a), val_t'(0));
        check("burst_level_end", val_t'(level_a), val_t'(0));
        check("burst_done_cnt", val_t'(done_cnt[0]), val_t'(5));

        // Single 0x55: latency and full cycle-accurate waveform
        c = cyc;
        valid_a = 1'b1; data_a = 8'h55;
        tick();
        valid_a = 1'b0;
        exp_q0.push_back('{8'h55, 1'b0});
        f = c + 3;
        fb = {1'b1, 8'h55, 1'b0};
        do @(negedge clk); while (cyc < f);
        for (int k = 0; k < 160; k++) begin
            wave[k]     = tx_a;
            exp_wave[k] = fb[k / DIV];
            @(negedge clk);
        end
        check("wave_55", wave, exp_wave);
        check("start_latency", val_t'(fall0[fall0.size()-1]), val_t'(f));
        check("single_busy_end", val_t'(busy_a), val_t'(0));
        check("single_done_cnt", val_t'(done_cnt[0]), val_t'(6));

        // Reset during data bit 3 of the first of three queued bytes
        tick();
        c = cyc;
        valid_a = 1'b1; data_a = 8'h11; tick();
        data_a = 8'h22; tick();
        data_a = 8'h33; tick();
        valid_a = 1'b0;
        f = c + 3;
        while (cyc < f + 70) tick();
        check("pre_rst_tx", val_t'(tx_a), val_t'(0));
        check("pre_rst_level", val_t'(level_a), val_t'(2));
        rst_a = 1'b1;
        tick();
        check("rst_tx", val_t'(tx_a), val_t'(1));
        check("rst_level", val_t'(level_a), val_t'(0));
        check("rst_busy", val_t'(busy_a), val_t'(0));
        check("rst_ready", val_t'(ready_a), val_t'(1));
        check("rst_done", val_t'(done_a), val_t'(0));
        tick();
        rst_a = 1'b0;
        f0 = fall0.size(); d0 = done_cnt[0]; r0 = rx_cnt[0];
        repeat (300) tick();
        check("rst_no_frames", val_t'(fall0.size()), val_t'(f0));
        check("rst_no_done", val_t'(done_cnt[0]), val_t'(d0));
        check("rst_no_rx", val_t'(rx_cnt[0]), val_t'(r0));
        check("rst_idle_tx", val_t'(tx_a), val_t'(1));

        // Push into an empty FIFO on the final STOP state cycle
        c = cyc;
        valid_a = 1'b1; data_a = 8'h5A; tick();
        valid_a = 1'b0;
        exp_q0.push_back('{8'h5A, 1'b0});
        f = c + 3;
        while (cyc < f + 158) tick();
        valid_a = 1'b1; data_a = 8'hC3; tick();
        valid_a = 1'b0;
        exp_q0.push_back('{8'hC3, 1'b0});
        check("corner_done", val_t'(done_a), val_t'(1));
        check("corner_idle", val_t'(busy_a), val_t'(0));
        check("corner_level", val_t'(level_a), val_t'(1));
        tick();
        check("corner_start", val_t'(busy_a), val_t'(1));
        check("corner_level_pop", val_t'(level_a), val_t'(0));
        wait_rx(0, r0 + 2, 400);
        check("corner_prev_fall", val_t'(fall0[fall0.size()-2]), val_t'(f));
        check("corner_next_fall", val_t'(fall0[fall0.size()-1]), val_t'(f + 161));
        repeat (20) tick();

        // Even parity instance: 0x07 -> parity 1, 0x03 -> parity 0
        c = cyc;
        valid_b = 1'b1; data_b = 8'h07; tick();
        data_b = 8'h03; tick();
        valid_b = 1'b0;
        exp_q1.push_back('{8'h07, 1'b1});
        exp_q1.push_back('{8'h03, 1'b0});
        f = c + 3;
        wait_rx(1, 2, 500);
        check("par_frames", val_t'(fall1.size()), val_t'(2));
        if (fall1.size() == 2) begin
            check("par_first_fall", val_t'(fall1[0]), val_t'(f));
            check("par_gap", val_t'(fall1[1] - fall1[0]), val_t'(11 * DIV));
        end
        repeat (20) tick();
        check("par_done_cnt", val_t'(done_cnt[1]), val_t'(2));
        check("par_busy_end", val_t'(busy_b), val_t'(0));

        check("sb_empty0", val_t'(exp_q0.size()), val_t'(0));
        check("sb_empty1", val_t'(exp_q1.size()), val_t'(0));
        check("total_done0", val_t'(done_cnt[0]), val_t'(8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
